mu0_control: RTL and testbench
==============================

# mu0_control

MU0 control unit: a fetch/execute state machine that drives the write enables of the 12-bit and 16-bit datapath registers (PC, IR, ACC), the datapath multiplexers, the ALU function and the memory strobes. It decodes the 4-bit opcode from IR[15:12] and the accumulator flags. It sits between the register/ALU datapath and the memory interface. It honours a memory Ready handshake so that slow memories insert wait states.

## Interface
Parameters: none.

- Clk  input  1  system clock; all state changes occur on its rising edge
- Reset  input  1  one clock; reset is synchronous and active-low (Reset=0 sampled on a rising Clk edge resets the block)
- F  input  4  opcode, IR[15:12]
- N  input  1  ACC negative flag, ACC[15]
- Z  input  1  ACC zero flag, ACC==0
- Ready  input  1  memory access completes this cycle
- Addr_sel  output  1  memory address: 0=PC, 1=IR[11:0]
- X_sel  output  1  ALU X operand: 0=ACC, 1=PC
- Y_sel  output  1  ALU Y operand: 0=memory data in, 1=IR[11:0] zero-extended
- ALU_fn  output  2  00=pass Y, 01=X+Y, 10=X+1, 11=X−Y
- Acc_En  output  1  ACC load enable
- PC_En  output  1  PC load enable
- IR_En  output  1  IR load enable
- Rd  output  1  memory read strobe
- Wr  output  1  memory write strobe; ACC drives write data
- Halted  output  1  high in HALT state
- Illegal  output  1  sticky illegal-opcode flag; tied 0 unless MU0_CTRL_ILLEGAL_TRAP_EN is defined

## Operation
- State register: FETCH, EXECUTE, HALT. Outputs are combinational from state, F, N, Z and Ready. There are no output registers.
- Unlisted outputs are 0. Don't-care selects are driven 0.
- FETCH: Addr_sel=0, Rd=1, X_sel=1, ALU_fn=10, IR_En=PC_En=Ready. The state moves to EXECUTE when Ready=1 and otherwise stays in FETCH.
- EXECUTE, by F:
  - 0 LDA: Addr_sel=1, Rd=1, Y_sel=0, ALU_fn=00, Acc_En=Ready.
  - 1 STA: Addr_sel=1, Wr=1. Registers are not enabled.
  - 2 ADD: Addr_sel=1, Rd=1, X_sel=0, Y_sel=0, ALU_fn=01, Acc_En=Ready.
  - 3 SUB: as ADD, with ALU_fn=11.
  - 4 JMP: Y_sel=1, ALU_fn=00, PC_En=1.
  - 5 JGE: as JMP, with PC_En=~N.
  - 6 JNE: as JMP, with PC_En=~Z.
  - 7 STP: no enables. Next state is HALT.
  - 8–F: handling depends on configuration (see Configuration).
- Memory opcodes (0–3) stay in EXECUTE while Ready=0; their strobes and selects are held and the enables stay 0. When Ready=1 they return to FETCH.
- Jump opcodes (4–6) ignore Ready and return to FETCH after one cycle.
- HALT: all enables and strobes are 0, Halted=1. The state is held until Reset.
- N and Z are sampled combinationally in the EXECUTE cycle of a conditional jump.

## Timing
- Reset (Reset=0 at a Clk edge): state becomes FETCH and Illegal becomes 0.
  - While Reset=0, every output is forced to 0 (Addr_sel, X_sel, Y_sel, ALU_fn=00, all enables, Rd, Wr, Halted, Illegal).
  - The first FETCH outputs appear in the first cycle in which Reset=1.
- Reset mid-instruction, including during a Ready wait or in HALT, aborts the instruction at that edge. No enable is asserted in the reset cycle.
- With zero waits, every instruction takes 2 cycles (FETCH + EXECUTE).
  - Each FETCH wait cycle adds 1 cycle.
  - Each EXECUTE wait cycle on opcodes 0–3 adds 1 cycle.
- STP: FETCH, then EXECUTE, then HALT from the following edge. Halted rises 2 cycles after STP's FETCH cycle.
- Ready has no effect in HALT, in jump EXECUTE cycles, or in STP's EXECUTE cycle.
- Ready may toggle every cycle. Only its value in the current cycle matters; nothing is latched.

## Configuration
Macro: MU0_CTRL_ILLEGAL_TRAP_EN.
- Defined: opcodes 8–F in EXECUTE assert no enables and go to HALT. The Illegal flip-flop sets at that edge and stays 1 until Reset. Halted=1 and Illegal=1 are then seen together.
- Undefined: opcodes 8–F behave as a single-cycle NOP (no enables, return to FETCH). Illegal is constant 0 and no flip-flop is synthesised.

## Test plan
- Reset: hold Reset=0 for 2 cycles with Ready=1 → all outputs 0. The first cycle after release shows Rd=1, IR_En=1, PC_En=1, ALU_fn=10, X_sel=1.
- LDA then ADD, zero waits, Ready=1, F=0 then F=2 → Acc_En=1 in cycles 2 and 4 with ALU_fn=00 then 01. Each instruction takes 2 cycles.
- Wait states: F=0, Ready=0 for 3 EXECUTE cycles then 1 → Rd=1 and Addr_sel=1 for 4 cycles, Acc_En=1 only in the 4th. The next FETCH starts in cycle 6.
- Conditional jumps: F=5 with N=1 → PC_En=0. F=5 with N=0 → PC_En=1. F=6 with Z=1 → PC_En=0. F=6 with Z=0 → PC_En=1. Each with Ready=0 still completes in 1 cycle.
- STP, then Reset mid-HALT: F=7 → Halted=1 from cycle 3 and stays 1 for 10 cycles. Reset=0 for 1 cycle → Halted=0 and FETCH resumes.
- Illegal opcode F=9:
  - Macro defined → Halted=1 and Illegal=1 after EXECUTE.
  - Macro undefined → FETCH resumes next cycle, with Illegal=0 throughout.

Source files
------------

// File: rtl/mu0_control.sv
// mu0_control: MU0 fetch/execute control FSM with memory Ready wait states.
// Optional sticky illegal-opcode trap enabled by MU0_CTRL_ILLEGAL_TRAP_EN.
module mu0_control (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  input  logic       Ready,
  output logic       Addr_sel,
  output logic       X_sel,
  output logic       Y_sel,
  output logic [1:0] ALU_fn,
  output logic       Acc_En,
  output logic       PC_En,
  output logic       IR_En,
  output logic       Rd,
  output logic       Wr,
  output logic       Halted,
  output logic       Illegal
);
  typedef enum logic [1:0] {FETCH, EXECUTE, HALT} state_t;
  state_t state_q, state_d;
  logic   trap;
  always_ff @(posedge Clk)
    if (!Reset) state_q <= FETCH;
    else        state_q <= state_d;
  always_comb begin
    state_d  = state_q;
    Addr_sel = 1'b0;
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    ALU_fn   = 2'b00;
    Acc_En   = 1'b0;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Rd       = 1'b0;
    Wr       = 1'b0;
    Halted   = 1'b0;
    trap     = 1'b0;
    case (state_q)
      FETCH: begin
        Rd      = 1'b1;
        X_sel   = 1'b1;
        ALU_fn  = 2'b10;
        IR_En   = Ready;
        PC_En   = Ready;
        state_d = Ready ? EXECUTE : FETCH;
      end
      EXECUTE: begin
        case (F)
          4'h0, 4'h1, 4'h2, 4'h3: begin
            Addr_sel = 1'b1;
            Rd       = F != 4'h1;
            Wr       = F == 4'h1;
            ALU_fn   = F == 4'h2 ? 2'b01 : F == 4'h3 ? 2'b11 : 2'b00;
            Acc_En   = Ready & (F != 4'h1);
            state_d  = Ready ? FETCH : EXECUTE;
          end
          4'h4, 4'h5, 4'h6: begin
            Y_sel   = 1'b1;
            PC_En   = F == 4'h4 ? 1'b1 : F == 4'h5 ? ~N : ~Z;
            state_d = FETCH;
          end
          4'h7: state_d = HALT;
          default: begin
`ifdef MU0_CTRL_ILLEGAL_TRAP_EN
            trap    = 1'b1;
            state_d = HALT;
`else
            state_d = FETCH;
`endif
          end
        endcase
      end
      HALT:    Halted  = 1'b1;
      default: state_d = FETCH;
    endcase
    if (!Reset) begin
      Addr_sel = 1'b0;
      X_sel    = 1'b0;
      Y_sel    = 1'b0;
      ALU_fn   = 2'b00;
      Acc_En   = 1'b0;
      PC_En    = 1'b0;
      IR_En    = 1'b0;
      Rd       = 1'b0;
      Wr       = 1'b0;
      Halted   = 1'b0;
    end
  end
`ifdef MU0_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  always_comb illegal_d = illegal_q | trap;
  always_ff @(posedge Clk)
    if (!Reset) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  assign Illegal = Reset & illegal_q;
`else
  logic unused_trap;
  assign unused_trap = trap;
  assign Illegal     = 1'b0;
`endif
endmodule

// File: tb/tb_mu0_control.sv
// tb_mu0_control: directed and random checks of mu0_control against an instruction-level model.
module tb_mu0_control;
  logic       Clk = 1'b0, Reset = 1'b0, N = 1'b0, Z = 1'b0, Ready = 1'b0;
  logic [3:0] F = 4'h0;
  logic       Addr_sel, X_sel, Y_sel, Acc_En, PC_En, IR_En, Rd, Wr, Halted, Illegal;
  logic [1:0] ALU_fn;
  int         tests = 0, fails = 0;
  // model: whether an opcode has been fetched, whether halted, sticky trap
  bit         m_fetched = 0, m_halted = 0, m_illegal = 0;
  mu0_control dut (
    .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Ready(Ready),
    .Addr_sel(Addr_sel), .X_sel(X_sel), .Y_sel(Y_sel), .ALU_fn(ALU_fn),
    .Acc_En(Acc_En), .PC_En(PC_En), .IR_En(IR_En), .Rd(Rd), .Wr(Wr),
    .Halted(Halted), .Illegal(Illegal)
  );
  always #5 Clk = ~Clk;
  function automatic logic [11:0] expect_out();
    logic a = 0, x = 0, y = 0, acc = 0, pc = 0, ir = 0, rd = 0, wr = 0, h = 0, il = 0;
    logic [1:0] fn = 2'b00;
    int op = int'(F);
    if (!Reset) return 12'h000;
    il = m_illegal;
    if (m_halted) h = 1;
    else if (!m_fetched) begin
      rd = 1; x = 1; fn = 2'b10; ir = Ready; pc = Ready;
    end else if (op <= 3) begin
      a = 1; wr = op == 1; rd = op != 1; acc = (op != 1) && Ready;
      fn = op == 2 ? 2'b01 : op == 3 ? 2'b11 : 2'b00;
    end else if (op <= 6) begin
      y = 1; pc = op == 4 || (op == 5 && !N) || (op == 6 && !Z);
    end
    return {a, x, y, fn, acc, pc, ir, rd, wr, h, il};
  endfunction
  task automatic step();
    int op = int'(F);
    if (!Reset) begin
      m_fetched = 0; m_halted = 0; m_illegal = 0;
    end else if (m_halted) begin
    end else if (!m_fetched) m_fetched = Ready;
    else if (op <= 3) m_fetched = !Ready;
    else if (op <= 7 || op >= 8) begin
      m_fetched = 0;
      if (op == 7) m_halted = 1;
`ifdef MU0_CTRL_ILLEGAL_TRAP_EN
      if (op >= 8) begin m_halted = 1; m_illegal = 1; end
`endif
    end
  endtask
  task automatic cyc(input logic rs, input logic [3:0] f, input logic n, input logic z,
                     input logic rdy, input string tag);
    logic [11:0] got, exp;
    Reset = rs; F = f; N = n; Z = z; Ready = rdy;
    #1;
    got = {Addr_sel, X_sel, Y_sel, ALU_fn, Acc_En, PC_En, IR_En, Rd, Wr, Halted, Illegal};
    exp = expect_out();
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b (F=%h N=%b Z=%b Ready=%b)", tag, got, exp, f, n, z, rdy);
    end
    @(posedge Clk);
    step();
    #1;
  endtask
  initial begin
    @(posedge Clk); #1;
    cyc(0, 4'h0, 0, 0, 1, "reset0");
    cyc(0, 4'h0, 0, 0, 1, "reset1");
    cyc(1, 4'h0, 0, 0, 1, "first_fetch");
    cyc(1, 4'h0, 0, 0, 1, "lda_exec");
    cyc(1, 4'h2, 0, 0, 1, "add_fetch");
    cyc(1, 4'h2, 0, 0, 1, "add_exec");
    cyc(1, 4'h0, 0, 0, 1, "wait_fetch");
    for (int i = 0; i < 3; i++) cyc(1, 4'h0, 0, 0, 0, "lda_wait");
    cyc(1, 4'h0, 0, 0, 1, "lda_done");
    cyc(1, 4'h1, 0, 0, 0, "fetch_stall");
    cyc(1, 4'h1, 0, 0, 1, "sta_fetch");
    cyc(1, 4'h1, 0, 0, 1, "sta_exec");
    cyc(1, 4'h3, 0, 0, 1, "sub_fetch");
    cyc(1, 4'h3, 0, 0, 1, "sub_exec");
    cyc(1, 4'h5, 1, 0, 1, "jge_fetch_n1");
    cyc(1, 4'h5, 1, 0, 0, "jge_n1");
    cyc(1, 4'h5, 0, 0, 1, "jge_fetch_n0");
    cyc(1, 4'h5, 0, 0, 0, "jge_n0");
    cyc(1, 4'h6, 0, 1, 1, "jne_fetch_z1");
    cyc(1, 4'h6, 0, 1, 0, "jne_z1");
    cyc(1, 4'h6, 0, 0, 1, "jne_fetch_z0");
    cyc(1, 4'h6, 0, 0, 0, "jne_z0");
    cyc(1, 4'h4, 1, 1, 1, "jmp_fetch");
    cyc(1, 4'h4, 1, 1, 0, "jmp_exec");
    cyc(1, 4'h9, 0, 0, 1, "ill_fetch");
    cyc(1, 4'h9, 0, 0, 1, "ill_exec");
    cyc(1, 4'h9, 0, 0, 1, "ill_after");
    cyc(1, 4'h9, 0, 0, 0, "ill_after2");
    cyc(0, 4'h7, 0, 0, 1, "reset_pre_stp");
    cyc(1, 4'h7, 0, 0, 1, "stp_fetch");
    cyc(1, 4'h7, 0, 0, 0, "stp_exec");
    for (int i = 0; i < 10; i++) cyc(1, 4'(i), 1'($urandom), 1'($urandom), 1'($urandom), "halt_hold");
    cyc(0, 4'h0, 0, 0, 1, "halt_reset");
    cyc(1, 4'h0, 0, 0, 1, "resume_fetch");
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 19) != 0), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "random");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
